load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 16, word-index width of the data memory; DATA_WIDTH, default 32, word width (only 32 is supported).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  unit idle; the request is accepted on req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request.
- mem_addr  out  DATA_WIDTH  word index to the memory, req_addr[ADDRESS_WIDTH+1:2] zero-extended.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data: registered, valid the cycle after the address is presented, and returning old contents on a same-cycle write.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 On accept, the unit SHALL register req_we, req_funct3, req_addr and req_wdata, then move to ISSUE, or to RESP with resp_err=1 if the request is illegal.
REQ-005 A request SHALL be illegal when any of these holds:
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- a load with funct3 in {3,6,7};
- a store with funct3>2.
REQ-006 An illegal request SHALL never assert mem_wen.
REQ-007 In ISSUE the unit SHALL drive mem_addr. A word store SHALL assert mem_wen=1 with mem_wdata=req_wdata for that cycle and go to RESP. All other requests SHALL keep mem_wen=0 and go to CAPTURE.
REQ-008 In CAPTURE, a load SHALL register the extracted value and go to RESP.
REQ-009 Load extraction SHALL select the byte at mem_rdata[8*addr[1:0]+:8] or the halfword at mem_rdata[16*addr[1]+:16], little-endian. B/H SHALL sign-extend; BU/HU SHALL zero-extend; W SHALL pass the word unchanged.
REQ-010 In CAPTURE, a sub-word store SHALL assert mem_wen=1 for exactly one cycle. mem_wdata SHALL equal mem_rdata with only the addressed byte or halfword replaced by the low bits of req_wdata. The state SHALL then move to RESP.
REQ-011 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_rdata and resp_err SHALL hold until the next RESP.
REQ-012 Latency from the accept edge to resp_valid SHALL be: load 3 cycles, sub-word store 3, word store 2, error 1.
REQ-013 Outside the cycles specified above, mem_wen SHALL be 0. req_valid outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-014 While rst_n=0 the unit SHALL hold: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_wen=0; mem_addr=0; mem_wdata=0; registered request fields=0.
REQ-015 Reset asserted mid-operation SHALL abort the operation immediately, with mem_wen deasserted asynchronously and no response issued.

Configuration
REQ-016 With LSU_SUBWORD_EN defined, all funct3 codes in REQ-005 SHALL be supported.
REQ-017 Without LSU_SUBWORD_EN, B/H/BU/HU requests SHALL be illegal and take the error path, the merge logic SHALL be absent, and CAPTURE SHALL be reached only by LW.

Structure
REQ-018 A shared package lsu_pkg SHALL hold the funct3 width enum, the FSM state enum, and the DATA_WIDTH default constant.
REQ-019 Extraction and merge logic SHALL live in a combinational sub-module lsu_align (inputs: rdata, wdata, addr[1:0], funct3; outputs: load value, merged word), instantiated once.

Verification
REQ-020 The bench SHALL model the memory per the mem_rdata definition, preloaded with word index 1 = 0x8899AABB.
REQ-021 The bench SHALL cover these directed scenarios:
- LB at 0x5 -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 3 cycles after accept, mem_wen never 1.
- LHU at 0x6 -> resp_rdata=0x00008899; LH at 0x4 -> 0xFFFFAABB.
- SB at 0x7 with wdata 0x12345611 -> exactly one mem_wen pulse with mem_addr=1, mem_wdata=0x1199AABB; a following LW at 0x4 -> 0x1199AABB.
- LW at 0x6 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, no mem_wen; without LSU_SUBWORD_EN, LB at 0x4 -> resp_err=1.
- rst_n pulled low in CAPTURE of SH at 0x4 -> mem_wen stays 0, no resp_valid, memory word unchanged, req_ready=1 after release.
- req_valid held high across back-to-back LW at 0x4 and 0x8 -> req_ready low from the first accept until the cycle after its resp_valid, second request accepted exactly once.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 width codes, FSM states,
// the default word width and the request legality check.
// Build option: LSU_SUBWORD_EN enables byte/halfword accesses; without it
// only aligned word accesses are legal.
package lsu_pkg;

   localparam int LSU_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      F3_B  = 3'd0,
      F3_H  = 3'd1,
      F3_W  = 3'd2,
      F3_BU = 3'd4,
      F3_HU = 3'd5
   } lsu_funct3_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } lsu_state_e;

   // True when the request must take the error path (bad code or misaligned)
   function automatic logic lsu_is_illegal(input logic       i_we,
                                           input logic [2:0] i_funct3,
                                           input logic [1:0] i_addr);
      logic v_ill;
`ifdef LSU_SUBWORD_EN
      case (i_funct3)
         F3_B:    v_ill = 1'b0;
         F3_BU:   v_ill = i_we;
         F3_H:    v_ill = i_addr[0];
         F3_HU:   v_ill = i_we | i_addr[0];
         F3_W:    v_ill = (i_addr != 2'b00);
         default: v_ill = 1'b1;
      endcase
`else
      v_ill = !((i_funct3 == F3_W) && (i_addr == 2'b00));
`endif
      return v_ill;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load extraction and store merge for one 32-bit word.
// Build option: LSU_SUBWORD_EN; without it loads pass the word and stores
// pass the write data, with no byte/halfword lanes at all.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

`ifdef LSU_SUBWORD_EN
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

   // Extend the addressed lane to a full word according to the width code
   always_comb begin
      o_load = i_rdata;
      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load = {24'd0, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load = {16'd0, w_half};
         default: o_load = i_rdata;
      endcase
   end

   // Replace only the addressed lane of the old word; word stores pass through
   always_comb begin
      o_merged = i_wdata;
      case (i_funct3)
         F3_B: begin
            o_merged = i_rdata;
            o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
         end
         F3_H: begin
            o_merged = i_rdata;
            o_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end
`else
   logic w_unused;

   assign o_load   = i_rdata;
   assign o_merged = i_wdata;
   assign w_unused = ^{i_addr, i_funct3};
`endif

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a registered-read memory.
// Build option: LSU_SUBWORD_EN enables B/H/BU/HU accesses with
// read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = LSU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // Handshake: a request is taken on the rising edge where req_valid and
   // req_ready are both 1; req_ready is 1 only in IDLE, so offers made while
   // busy are dropped, and resp_valid is a single-cycle pulse per request.

   lsu_state_e               r_state;
   logic                     r_req_ready;
   logic                     r_resp_valid;
   logic                     r_resp_err;
   logic [31:0]              r_resp_rdata;
   logic                     r_mem_wen;
   logic                     r_we;
   logic [2:0]               r_funct3;
   logic [ADDRESS_WIDTH+1:0] r_addr;
   logic [31:0]              r_wdata;
   logic [31:0]              w_load;
   logic [31:0]              w_merged;
   logic                     w_req_illegal;

   assign w_req_illegal = lsu_is_illegal(req_we, req_funct3, req_addr[1:0]);

   lsu_align u_align (
      .i_rdata  (mem_rdata),
      .i_wdata  (r_wdata),
      .i_addr   (r_addr[1:0]),
      .i_funct3 (r_funct3),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign mem_wen    = r_mem_wen;
   assign mem_addr   = DATA_WIDTH'(r_addr[ADDRESS_WIDTH+1:2]);
   // Merged word depends on mem_rdata, which is only valid in CAPTURE
   assign mem_wdata  = r_mem_wen ? w_merged : '0;

   // Request FSM with registered handshake, response and write-enable outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_wen    <= 1'b0;
         r_we         <= 1'b0;
         r_funct3     <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         r_mem_wen    <= 1'b0;
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_funct3    <= req_funct3;
                  r_addr      <= req_addr[ADDRESS_WIDTH+1:0];
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_req_illegal) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= '0;
                  end else begin
                     r_state   <= S_ISSUE;
                     r_mem_wen <= req_we && (req_funct3 == F3_W);
                  end
               end
            end
            S_ISSUE: begin
               if (r_we && (r_funct3 == F3_W)) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= '0;
               end else begin
                  // Sub-word stores write back the merged word during CAPTURE
                  r_state   <= S_CAPTURE;
                  r_mem_wen <= r_we;
               end
            end
            S_CAPTURE: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= r_we ? 32'd0 : w_load;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
